// File: rtl/reservation_station_pkg.sv
// Shared types, sizes and helpers for the reservation station slice.
package reservation_station_pkg;

    localparam int RS_DEPTH = 16;
    localparam int NUM_FU   = 3;
    localparam int TAG_W    = 6;
    localparam int ROB_W    = 4;
    localparam int ROB_SPAN = 16;
    localparam int FU_W     = 2;
    localparam int CDB_N    = 3;

    localparam logic [FU_W-1:0] FU_ALU0 = 2'b00;
    localparam logic [FU_W-1:0] FU_ALU1 = 2'b01;
    localparam logic [FU_W-1:0] FU_MEM  = 2'b10;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       RegWrite;
        logic [3:0] ALUOp;
    } ctrlStruct;

    typedef struct packed {
        logic             valid;
        ctrlStruct        control;
        logic [TAG_W-1:0] rd;
        logic [TAG_W-1:0] rs1;
        logic [TAG_W-1:0] rs2;
        logic             src1rdy;
        logic             src2rdy;
        logic [FU_W-1:0]  fu;
        logic [ROB_W-1:0] robNum;
        logic [15:0]      imm;
    } rsEntry;

    typedef struct packed {
        rsEntry line_a;
        rsEntry line_b;
    } dispatchStruct;

    // Mark sources ready for every CDB tag match; an immediate second operand
    // (ALUSrc) never waits on rs2, so it is left untouched.
    function automatic rsEntry apply_wakeup(input rsEntry e,
                                            input logic [CDB_N-1:0] cv,
                                            input logic [CDB_N-1:0][TAG_W-1:0] ct);
        rsEntry r;
        r = e;
        for (int k = 0; k < CDB_N; k++) begin
            if (e.valid && cv[k]) begin
                if (e.rs1 == ct[k]) r.src1rdy = 1'b1;
                if ((e.rs2 == ct[k]) && !e.control.ALUSrc) r.src2rdy = 1'b1;
            end
        end
        return r;
    endfunction

    // Oldest robNum in a circular occupancy map: in-flight robNums form an arc,
    // so the oldest one is the set bit preceded by the longest run of zeros.
    function automatic logic [ROB_W-1:0] oldest_rob(input logic [ROB_SPAN-1:0] map);
        logic [ROB_W-1:0] best;
        logic [ROB_W-1:0] idx;
        int               best_gap;
        int               gap;
        logic             run;
        best     = '0;
        best_gap = -1;
        for (int r = 0; r < ROB_SPAN; r++) begin
            if (map[r]) begin
                gap = 0;
                run = 1'b1;
                for (int k = 1; k < ROB_SPAN; k++) begin
                    idx = ROB_W'(r) - ROB_W'(k);
                    if (run && !map[idx]) gap++;
                    else run = 1'b0;
                end
                if (gap > best_gap) begin
                    best_gap = gap;
                    best     = ROB_W'(r);
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Per-port select: oldest ready slot relative to the oldest occupied robNum,
// ties broken toward the lowest slot index.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]                ready,
    input  logic [DEPTH-1:0][ROB_W-1:0]     rob,
    input  logic [ROB_W-1:0]                oldest,
    output logic                            sel_valid,
    output logic [$clog2(DEPTH)-1:0]        sel_idx
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ROB_W-1:0] age;
    logic [ROB_W-1:0] best_age;

    // Linear scan; strict less-than keeps the lowest index on equal age.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '1;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = rob[i] - oldest;
            if (ready[i] && (!sel_valid || (age < best_age))) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: two-wide dispatch into free slots, CDB wakeup with
// dispatch-cycle bypass, and per-FU oldest-ready issue into registered ports.
module reservation_station
    import reservation_station_pkg::rsEntry;
    import reservation_station_pkg::dispatchStruct;
    import reservation_station_pkg::TAG_W;
    import reservation_station_pkg::ROB_W;
    import reservation_station_pkg::ROB_SPAN;
    import reservation_station_pkg::FU_W;
    import reservation_station_pkg::CDB_N;
    import reservation_station_pkg::apply_wakeup;
    import reservation_station_pkg::oldest_rob;
#(
    parameter int RS_DEPTH = reservation_station_pkg::RS_DEPTH,
    parameter int NUM_FU   = reservation_station_pkg::NUM_FU
) (
    input  logic                            clk,
    input  logic                            reset,
    input  rsEntry                          rsLine_a,
    input  rsEntry                          rsLine_b,
    input  logic [CDB_N-1:0]                cdb_valid,
    input  logic [CDB_N-1:0][TAG_W-1:0]     cdb_tag,
    output logic [NUM_FU-1:0]               issue_valid,
    output rsEntry [NUM_FU-1:0]             issue_entry,
    output logic                            rs_full,
    output logic                            drop_err
);

    // Valid semantics: a dispatch line is offered when its .valid is high and is
    // taken at the next edge unless rs_full is high, in which case it is lost and
    // drop_err pulses. Issue ports carry no back-pressure: issue_valid[p] high
    // means issue_entry[p] is a real instruction for exactly one cycle.

    localparam int IDX_W = $clog2(RS_DEPTH);

    rsEntry                           slot_q [RS_DEPTH];
    rsEntry                           slot_d [RS_DEPTH];
    dispatchStruct                    disp;
    logic [RS_DEPTH-1:0]              occ;
    logic [RS_DEPTH-1:0][ROB_W-1:0]   slot_rob;
    logic [ROB_SPAN-1:0]              rob_map;
    logic [ROB_W-1:0]                 oldest;
    logic [NUM_FU-1:0][RS_DEPTH-1:0]  port_ready;
    logic [NUM_FU-1:0]                sel_valid;
    logic [NUM_FU-1:0][IDX_W-1:0]     sel_idx;
    logic                             a_found;
    logic                             b_found;
    logic [IDX_W-1:0]                 a_idx;
    logic [IDX_W-1:0]                 b_idx;
    logic [IDX_W-1:0]                 b_slot;
    logic                             alloc_a;
    logic                             alloc_b;
    logic [NUM_FU-1:0]                issue_valid_d;
    rsEntry [NUM_FU-1:0]              issue_entry_d;
    logic [IDX_W:0]                   free_cnt;
    logic                             rs_full_d;
    logic                             drop_err_d;

    assign disp.line_a = rsLine_a;
    assign disp.line_b = rsLine_b;

    // Occupancy, robNum map and per-port ready vectors from registered state.
    always_comb begin
        occ        = '0;
        slot_rob   = '0;
        rob_map    = '0;
        port_ready = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            occ[i]      = slot_q[i].valid;
            slot_rob[i] = slot_q[i].robNum;
            if (slot_q[i].valid) rob_map[slot_q[i].robNum] = 1'b1;
            for (int p = 0; p < NUM_FU; p++) begin
                if (slot_q[i].valid && slot_q[i].src1rdy && slot_q[i].src2rdy &&
                    (slot_q[i].fu == FU_W'(p)))
                    port_ready[p][i] = 1'b1;
            end
        end
    end

    assign oldest = oldest_rob(rob_map);

    // One selector per issue port; fu codes are distinct per port so no slot
    // can win on two ports.
    for (genvar p = 0; p < NUM_FU; p++) begin : g_sel
        rs_select #(.DEPTH(RS_DEPTH)) u_sel (
            .ready     (port_ready[p]),
            .rob       (slot_rob),
            .oldest    (oldest),
            .sel_valid (sel_valid[p]),
            .sel_idx   (sel_idx[p])
        );
    end

    // Two lowest free slots; slots freed by this edge's issue are not counted.
    always_comb begin
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!occ[i]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = IDX_W'(i);
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = IDX_W'(i);
                end
            end
        end
        alloc_a = disp.line_a.valid && !rs_full && a_found;
        b_slot  = disp.line_a.valid ? b_idx : a_idx;
        alloc_b = disp.line_b.valid && !rs_full && (disp.line_a.valid ? b_found : a_found);
    end

    // Next slot contents: wakeup everywhere, free issued slots, write new lines.
    always_comb begin
        issue_valid_d = '0;
        issue_entry_d = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            slot_d[i] = apply_wakeup(slot_q[i], cdb_valid, cdb_tag);
        end
        for (int p = 0; p < NUM_FU; p++) begin
            if (sel_valid[p]) begin
                issue_valid_d[p]      = 1'b1;
                issue_entry_d[p]      = slot_q[sel_idx[p]];
                slot_d[sel_idx[p]]    = '0;
            end
        end
        if (alloc_a) slot_d[a_idx]  = apply_wakeup(disp.line_a, cdb_valid, cdb_tag);
        if (alloc_b) slot_d[b_slot] = apply_wakeup(disp.line_b, cdb_valid, cdb_tag);
        free_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!slot_d[i].valid) free_cnt = free_cnt + (IDX_W+1)'(1);
        end
        rs_full_d  = (free_cnt < (IDX_W+1)'(2));
        drop_err_d = rs_full && (disp.line_a.valid || disp.line_b.valid);
    end

    // State and registered outputs; reset empties the station.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) slot_q[i] <= '0;
            issue_valid <= '0;
            issue_entry <= '0;
            rs_full     <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) slot_q[i] <= slot_d[i];
            issue_valid <= issue_valid_d;
            issue_entry <= issue_entry_d;
            rs_full     <= rs_full_d;
            drop_err    <= drop_err_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench: a per-cycle vector table for the issue scenarios, then
// hand-written sequences for fill/drop and reset-with-occupancy.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    rsEntry                   rsLine_a;
    rsEntry                   rsLine_b;
    logic [2:0]               cdb_valid;
    logic [2:0][5:0]          cdb_tag;
    logic [2:0]               issue_valid;
    rsEntry [2:0]             issue_entry;
    logic                     rs_full;
    logic                     drop_err;

    int                       checks = 0;
    int                       errors = 0;
    logic [ROB_W-1:0]         exp_q[$];

    typedef struct {
        logic            rst;
        rsEntry          a;
        rsEntry          b;
        logic [2:0]      cv;
        logic [2:0][5:0] ct;
        logic [2:0]      iv;
        logic [2:0][3:0] rob;
        logic            full;
        logic            drop;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    reservation_station #(.RS_DEPTH(16), .NUM_FU(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .rsLine_a    (rsLine_a),
        .rsLine_b    (rsLine_b),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .rs_full     (rs_full),
        .drop_err    (drop_err)
    );

    // Clock and overall time limit.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic rsEntry mk(input logic [3:0] rob, input logic [1:0] fu,
                                  input logic [5:0] rs1, input logic [5:0] rs2,
                                  input logic r1, input logic r2, input logic alusrc);
        rsEntry e;
        e                  = '0;
        e.valid            = 1'b1;
        e.control.ALUSrc   = alusrc;
        e.control.RegWrite = 1'b1;
        e.rd               = {2'b01, rob};
        e.rs1              = rs1;
        e.rs2              = rs2;
        e.src1rdy          = r1;
        e.src2rdy          = r2;
        e.fu               = fu;
        e.robNum           = rob;
        return e;
    endfunction

    function automatic vec_t blank();
        vec_t b;
        b.rst  = 1'b0;
        b.a    = '0;
        b.b    = '0;
        b.cv   = '0;
        b.ct   = '0;
        b.iv   = '0;
        b.rob  = '0;
        b.full = 1'b0;
        b.drop = 1'b0;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsLine_a  = '0;
        rsLine_b  = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst issue_valid", 64'(issue_valid), 64'(0));
        chk("rst issue_entry", 64'(issue_entry), 64'(0));
        chk("rst rs_full", 64'(rs_full), 64'(0));
        chk("rst drop_err", 64'(drop_err), 64'(0));
        reset = 1'b0;
    endtask

    // Waits a bounded number of edges for a port-0 issue and scores its robNum.
    task automatic wait_issue0(input string name);
        int n;
        n = 0;
        while (!issue_valid[0] && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (!issue_valid[0]) begin
            errors++;
            $display("FAIL %s: no issue on port 0 within 8 cycles", name);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: issue of rob %0d with nothing expected", name, issue_entry[0].robNum);
        end else begin
            logic [ROB_W-1:0] e;
            e = exp_q.pop_front();
            if (issue_entry[0].robNum !== e) begin
                errors++;
                $display("FAIL %s: got rob %0d expected rob %0d", name, issue_entry[0].robNum, e);
            end
        end
    endtask

    initial begin
        idle_inputs();

        // Vector table: inputs before an edge, expected outputs after it.
        v = blank(); v.rst = 1'b1; vecs.push_back(v);
        v = blank(); v.a = mk(4'd0, FU_ALU0, 6'd1, 6'd2, 1, 1, 0); vecs.push_back(v);
        v = blank(); v.iv = 3'b001; v.rob[0] = 4'd0; vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); v.a = mk(4'd1, FU_ALU0, 6'd7, 6'd2, 0, 1, 0); vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); v.cv = 3'b001; v.ct[0] = 6'd7; vecs.push_back(v);
        v = blank(); v.iv = 3'b001; v.rob[0] = 4'd1; vecs.push_back(v);
        v = blank(); v.a = mk(4'd2, FU_ALU1, 6'd3, 6'd9, 1, 0, 0);
                     v.cv = 3'b010; v.ct[1] = 6'd9; vecs.push_back(v);
        v = blank(); v.iv = 3'b010; v.rob[1] = 4'd2; vecs.push_back(v);
        v = blank(); v.a = mk(4'd4, FU_MEM, 6'd1, 6'd2, 1, 1, 0);
                     v.b = mk(4'd2, FU_MEM, 6'd1, 6'd2, 1, 1, 0); vecs.push_back(v);
        v = blank(); v.a = mk(4'd8, FU_ALU1, 6'd1, 6'd2, 1, 1, 0);
                     v.iv = 3'b100; v.rob[2] = 4'd2; vecs.push_back(v);
        v = blank(); v.iv = 3'b110; v.rob[1] = 4'd8; v.rob[2] = 4'd4; vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); v.a = mk(4'd5, FU_ALU0, 6'd1, 6'd2, 1, 1, 0);
                     v.b = mk(4'd6, FU_ALU1, 6'd1, 6'd2, 1, 1, 0); vecs.push_back(v);
        v = blank(); v.iv = 3'b011; v.rob[0] = 4'd5; v.rob[1] = 4'd6; vecs.push_back(v);
        v = blank(); v.a = mk(4'd7, FU_ALU0, 6'd4, 6'd11, 1, 0, 1); vecs.push_back(v);
        v = blank(); v.cv = 3'b100; v.ct[2] = 6'd11; vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); v.a = mk(4'd10, FU_ALU0, 6'd1, 6'd2, 1, 1, 0);
                     v.b = mk(4'd9, FU_ALU0, 6'd1, 6'd2, 1, 1, 0); vecs.push_back(v);
        v = blank(); v.iv = 3'b001; v.rob[0] = 4'd9; vecs.push_back(v);
        v = blank(); v.iv = 3'b001; v.rob[0] = 4'd10; vecs.push_back(v);
        v = blank(); vecs.push_back(v);
        v = blank(); v.a = mk(4'd1, FU_ALU1, 6'd1, 6'd2, 1, 1, 0);
                     v.b = mk(4'd14, FU_ALU1, 6'd1, 6'd2, 1, 1, 0); vecs.push_back(v);
        v = blank(); v.iv = 3'b010; v.rob[1] = 4'd14; vecs.push_back(v);
        v = blank(); v.iv = 3'b010; v.rob[1] = 4'd1; vecs.push_back(v);
        v = blank(); v.rst = 1'b1; vecs.push_back(v);

        for (int k = 0; k < vecs.size(); k++) begin
            reset     = vecs[k].rst;
            rsLine_a  = vecs[k].a;
            rsLine_b  = vecs[k].b;
            cdb_valid = vecs[k].cv;
            cdb_tag   = vecs[k].ct;
            tick();
            chk($sformatf("v%0d issue_valid", k), 64'(issue_valid), 64'(vecs[k].iv));
            for (int p = 0; p < 3; p++) begin
                if (vecs[k].iv[p])
                    chk($sformatf("v%0d port%0d robNum", k, p),
                        64'(issue_entry[p].robNum), 64'(vecs[k].rob[p]));
                else
                    chk($sformatf("v%0d port%0d idle entry", k, p),
                        64'(issue_entry[p]), 64'(0));
            end
            chk($sformatf("v%0d rs_full", k), 64'(rs_full), 64'(vecs[k].full));
            chk($sformatf("v%0d drop_err", k), 64'(drop_err), 64'(vecs[k].drop));
        end

        // Fill all 16 slots with waiting ALU0 entries, then overflow.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rsLine_a = mk(4'(2*k),   FU_ALU0, 6'(32 + 2*k), 6'd0, 0, 1, 0);
            rsLine_b = mk(4'(2*k+1), FU_ALU0, 6'(33 + 2*k), 6'd0, 0, 1, 0);
            tick();
            chk($sformatf("fill%0d rs_full", k), 64'(rs_full), 64'(k == 7));
            chk($sformatf("fill%0d issue_valid", k), 64'(issue_valid), 64'(0));
        end
        rsLine_a = mk(4'd0, FU_ALU1, 6'd1, 6'd2, 1, 1, 0);
        rsLine_b = mk(4'd1, FU_ALU1, 6'd1, 6'd2, 1, 1, 0);
        tick();
        chk("overflow drop_err", 64'(drop_err), 64'(1));
        chk("overflow rs_full", 64'(rs_full), 64'(1));
        idle_inputs();
        tick();
        chk("after drop drop_err", 64'(drop_err), 64'(0));
        chk("dropped lines absent", 64'(issue_valid), 64'(0));

        cdb_valid = 3'b001;
        cdb_tag[0] = 6'd35;
        exp_q.push_back(4'd3);
        tick();
        idle_inputs();
        wait_issue0("wake rob3");
        chk("one free rs_full", 64'(rs_full), 64'(1));
        cdb_valid = 3'b010;
        cdb_tag[1] = 6'd40;
        exp_q.push_back(4'd8);
        tick();
        idle_inputs();
        wait_issue0("wake rob8");
        chk("two free rs_full", 64'(rs_full), 64'(0));
        chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

        // Reset with five waiting entries; their tags broadcast afterwards.
        do_reset();
        rsLine_a = mk(4'd0, FU_ALU0, 6'd50, 6'd0, 0, 1, 0);
        rsLine_b = mk(4'd1, FU_ALU0, 6'd51, 6'd0, 0, 1, 0);
        tick();
        rsLine_a = mk(4'd2, FU_ALU0, 6'd52, 6'd0, 0, 1, 0);
        rsLine_b = mk(4'd3, FU_ALU0, 6'd53, 6'd0, 0, 1, 0);
        tick();
        rsLine_a = mk(4'd4, FU_ALU0, 6'd54, 6'd0, 0, 1, 0);
        rsLine_b = '0;
        tick();
        chk("five held rs_full", 64'(rs_full), 64'(0));
        reset     = 1'b1;
        rsLine_a  = mk(4'd5, FU_ALU0, 6'd1, 6'd2, 1, 1, 0);
        cdb_valid = 3'b111;
        cdb_tag   = {6'd52, 6'd51, 6'd50};
        tick();
        chk("midreset rs_full", 64'(rs_full), 64'(0));
        chk("midreset issue_valid", 64'(issue_valid), 64'(0));
        chk("midreset drop_err", 64'(drop_err), 64'(0));
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            cdb_valid = 3'b111;
            cdb_tag   = (k % 2 == 0) ? {6'd52, 6'd51, 6'd50} : {6'd54, 6'd54, 6'd53};
            tick();
            chk($sformatf("stale%0d issue_valid", k), 64'(issue_valid), 64'(0));
        end
        idle_inputs();
        tick();
        chk("stale final issue_valid", 64'(issue_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_DEPTH, default 16, number of reservation-station entries; SHALL be a power of two, at least 4.
REQ-002 Parameter NUM_FU, default 3, issue ports: 0 = ALU0, 1 = ALU1, 2 = MEM (fu codes 2'b00/2'b01/2'b10).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rsLine_a  in  rsEntry  first dispatched line; accepted only when .valid=1.
REQ-006 rsLine_b  in  rsEntry  second dispatched line; accepted only when .valid=1.
REQ-007 cdb_valid  in  3  per-slot completion broadcast valid.
REQ-008 cdb_tag  in  3x6  per-slot physical destination register that completed.
REQ-009 issue_valid  out  NUM_FU  registered; one bit per FU port.
REQ-010 issue_entry  out  NUM_FU x rsEntry  registered; entry issued on each port.
REQ-011 rs_full  out  1  registered; asserted when fewer than 2 slots are free.
REQ-012 drop_err  out  1  registered one-cycle pulse when a valid incoming line was discarded.

Function
REQ-013 Allocation: valid incoming lines SHALL be written into the lowest-index free slots, a before b, at the rising edge.
REQ-014 A line arriving while rs_full=1 SHALL be discarded, and drop_err SHALL pulse in the next cycle; occupied slots SHALL be unaffected.
REQ-015 Wakeup: for each occupied slot and cdb slot k with cdb_valid[k]=1, rs1==cdb_tag[k] SHALL set src1rdy; rs2==cdb_tag[k] SHALL set src2rdy unless control.ALUSrc=1.
REQ-016 Incoming lines SHALL be compared against the same cycle's CDB tags before being written (bypass), so no wakeup is lost.
REQ-017 Ready rule: a slot is ready when occupied, src1rdy=1 and src2rdy=1.
REQ-018 Select: per FU port, choose the ready slot with matching fu whose robNum is oldest relative to the oldest occupied robNum (modulo 16); ties go to the lowest index.
REQ-019 Each port SHALL issue at most one entry per cycle, and no slot SHALL issue on two ports.
REQ-020 An issued slot SHALL be freed on the same edge that loads issue_entry; that slot is reusable for allocation at the next edge, not the same one.
REQ-021 Latency: an entry written ready at edge E SHALL appear with issue_valid=1 after edge E+1, provided its port is uncontended.
REQ-022 An entry woken at edge E SHALL be selectable for the edge E+1 issue.
REQ-023 issue_valid[p]=0 SHALL force issue_entry[p] to all zeros.
REQ-024 rs_full SHALL be computed from the occupancy after the current edge's allocations and frees.
REQ-025 Simultaneous allocate, wakeup and issue in one cycle SHALL all take effect; the free count SHALL change by +issued-allocated.

Reset
REQ-026 While reset=1 at an edge, all slots SHALL be cleared to unoccupied.
REQ-027 While reset=1 at an edge, issue_valid, issue_entry, rs_full and drop_err SHALL be cleared to 0.
REQ-028 While reset=1, incoming lines SHALL be ignored; reset mid-operation discards all in-flight entries, with no drop_err.

Structure
REQ-029 The package typedefs SHALL hold RS_DEPTH, NUM_FU, the FU code constants, and the rsEntry/dispatchStruct types.
REQ-030 One sub-module, rs_select, SHALL implement the per-port oldest-ready priority select; it is instantiated NUM_FU times.

Verification
REQ-031 Scenario 1: reset, then a=ADD rd=5 rs1=1 rs2=2, both ready, fu=0, robNum=0 -> issue_valid=3'b001 two edges later, issue_entry[0].robNum=0.
REQ-032 Scenario 2: a not ready on rs1=7; cdb_valid=1, cdb_tag=7 three cycles later -> issue on ALU0 the edge after the wakeup.
REQ-033 Scenario 3: line arrives with rs2=9 in the same cycle cdb_tag=9 is broadcast -> written with src2rdy=1, with no extra wait.
REQ-034 Scenario 4: fill 16 slots with non-ready entries -> rs_full=1 after slot 15 is written; next valid pair discarded, drop_err=1 for one cycle.
REQ-035 Scenario 5: two ready MEM entries with robNum 4 and 2 -> robNum 2 issues first on port 2, and robNum 4 issues the next cycle.
REQ-036 Scenario 6: reset asserted with 5 entries occupied -> after one edge, rs_full=0 and issue_valid=0, and no stale entry ever issues.
